// File: rtl/line_shift_ram_multi.sv
// Multi-line delay buffer: TAPS chained line RAMs present the current pixel
// together with the same column from each of the TAPS previous lines.
// Adds output valid, per-frame line counting, border fill for lines not yet
// filled this frame, and sticky line-length overflow detection.
module line_shift_ram_multi #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TAPS        = 2,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     per_frame_vsync,
    input  logic                     per_frame_href,
    input  logic                     clken,
    input  logic [DATA_W-1:0]        shiftin,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        cur_pix,
    output logic [TAPS*DATA_W-1:0]   taps,
    output logic [2:0]               line_cnt,
    output logic                     lines_ready,
    output logic                     overflow
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]      TAPS_CNT = 3'(TAPS);

    logic                accept;
    logic                href_d;
    logic                vsync_d;
    logic                href_fall;
    logic                vsync_rise;
    logic [ADDR_W-1:0]   col;
    logic                col_full;
    logic                ovf_hit;
    logic                line_has_px;
    logic [2:0]          line_cnt_nxt;

    logic                s1_valid;
    logic                s1_ovf;
    logic [DATA_W-1:0]   s1_pix;
    logic [ADDR_W-1:0]   s1_col;

    logic [DATA_W-1:0]   rd_data [TAPS];
    logic [2:0]          eff_cnt;
    logic [DATA_W-1:0]   fill;
    logic [TAPS*DATA_W-1:0] taps_nxt;

    assign accept     = clken & per_frame_href;
    assign href_fall  = href_d & ~per_frame_href;
    assign vsync_rise = per_frame_vsync & ~vsync_d;
    // Once the last column has been used, further pixels in the line overflow.
    assign ovf_hit    = accept & col_full;

    // Line counter next value: frame start wins over a same-cycle line end.
    always_comb begin
        line_cnt_nxt = line_cnt;
        if (vsync_rise) begin
            line_cnt_nxt = 3'd0;
        end else if (href_fall && line_has_px && (line_cnt != TAPS_CNT)) begin
            line_cnt_nxt = line_cnt + 3'd1;
        end
    end

    // Column counter, edge detectors, line/frame bookkeeping and overflow flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            href_d      <= 1'b0;
            vsync_d     <= 1'b0;
            col         <= '0;
            col_full    <= 1'b0;
            line_has_px <= 1'b0;
            line_cnt    <= 3'd0;
            lines_ready <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            href_d      <= per_frame_href;
            vsync_d     <= per_frame_vsync;
            line_cnt    <= line_cnt_nxt;
            lines_ready <= (line_cnt_nxt == TAPS_CNT);
            if (!per_frame_href) begin
                col      <= '0;
                col_full <= 1'b0;
            end else if (accept) begin
                if (col == COL_MAX) begin
                    col_full <= 1'b1;
                end else begin
                    col <= col + ADDR_W'(1);
                end
            end
            if (href_fall) begin
                line_has_px <= 1'b0;
            end else if (accept) begin
                line_has_px <= 1'b1;
            end
            if (vsync_rise) begin
                overflow <= 1'b0;
            end else if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stage 1: remember the accepted pixel and its column for the RAM write-back.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ovf <= ovf_hit;
                s1_pix <= shiftin;
                s1_col <= col;
            end
        end
    end

    // Line RAM chain: RAM0 takes the new pixel, RAM k takes RAM k-1's old value.
    for (genvar k = 0; k < TAPS; k++) begin : g_ram
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] wr_data;
        logic [DATA_W-1:0] rd_q;

        if (k == 0) begin : g_head
            assign wr_data = s1_pix;
        end else begin : g_chain
            assign wr_data = rd_data[k-1];
        end

        // Read at accept, write one cycle later at the same column.
        always_ff @(posedge clock) begin
            if (s1_valid && !s1_ovf) begin
                mem[s1_col] <= wr_data;
            end
            if (accept) begin
                rd_q <= mem[col];
            end
        end

        assign rd_data[k] = rd_q;
    end

    // Border fill: taps at or beyond the filled-line count are masked.
    always_comb begin
        eff_cnt  = s1_ovf ? 3'd0 : line_cnt;
        fill     = '0;
        taps_nxt = '0;
        if (BORDER_MODE != 0) begin
            fill = s1_pix;
            for (int unsigned j = 0; j < TAPS; j++) begin
                if (eff_cnt == 3'(j + 1)) begin
                    fill = rd_data[j];
                end
            end
        end
        for (int unsigned k = 0; k < TAPS; k++) begin
            taps_nxt[k*DATA_W +: DATA_W] = (3'(k) < eff_cnt) ? rd_data[k] : fill;
        end
    end

    // Stage 2: registered outputs, valid two clocks after the accept.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cur_pix   <= '0;
            taps      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                cur_pix <= s1_pix;
                taps    <= taps_nxt;
            end
        end
    end

endmodule

// File: tb/tb_line_shift_ram_multi.sv
// Bench for line_shift_ram_multi: four parameter variants share one stimulus
// stream and are checked against a per-column line-history model.
module tb_line_shift_ram_multi;

    localparam int NI = 4;

    logic       clock;
    logic       rst_n;
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] shiftin;

    logic [NI-1:0] ov;
    logic [NI-1:0] lr;
    logic [NI-1:0] of;
    logic [7:0]    cp [NI];
    logic [2:0]    lc [NI];
    logic [15:0]   tp0;
    logic [15:0]   tp1;
    logic [23:0]   tp2;
    logic [31:0]   tp3;

    int n_tests = 0;
    int n_fail  = 0;

    line_shift_ram_multi #(.DATA_W(8), .TAPS(2), .ADDR_W(4), .BORDER_MODE(0)) u_d0 (
        .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .clken(clken), .shiftin(shiftin), .out_valid(ov[0]), .cur_pix(cp[0]), .taps(tp0),
        .line_cnt(lc[0]), .lines_ready(lr[0]), .overflow(of[0]));
    line_shift_ram_multi #(.DATA_W(8), .TAPS(2), .ADDR_W(4), .BORDER_MODE(1)) u_d1 (
        .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .clken(clken), .shiftin(shiftin), .out_valid(ov[1]), .cur_pix(cp[1]), .taps(tp1),
        .line_cnt(lc[1]), .lines_ready(lr[1]), .overflow(of[1]));
    line_shift_ram_multi #(.DATA_W(8), .TAPS(3), .ADDR_W(5), .BORDER_MODE(1)) u_d2 (
        .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .clken(clken), .shiftin(shiftin), .out_valid(ov[2]), .cur_pix(cp[2]), .taps(tp2),
        .line_cnt(lc[2]), .lines_ready(lr[2]), .overflow(of[2]));
    line_shift_ram_multi #(.DATA_W(8), .TAPS(4), .ADDR_W(6), .BORDER_MODE(0)) u_d3 (
        .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .clken(clken), .shiftin(shiftin), .out_valid(ov[3]), .cur_pix(cp[3]), .taps(tp3),
        .line_cnt(lc[3]), .lines_ready(lr[3]), .overflow(of[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int tp_of(input int i);
        case (i)
            0, 1:    return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int aw_of(input int i);
        case (i)
            0, 1:    return 4;
            2:       return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int bm_of(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic logic [31:0] taps_of(input int i);
        case (i)
            0:       return 32'(tp0);
            1:       return 32'(tp1);
            2:       return 32'(tp2);
            default: return tp3;
        endcase
    endfunction

    // Reference model: per instance, the column history of previous lines.
    typedef struct {
        bit          v;
        logic [7:0]  cur;
        logic [31:0] t;
        logic [3:0]  kn;
    } rec_t;

    logic [7:0] hist [NI][4][64];
    bit         hkn  [NI][4][64];
    int         mlc  [NI];
    bit         movf [NI];
    int         nline[NI];
    bit         had  [NI];
    bit         hr_prev;
    bit         vs_prev;
    rec_t       last [NI];
    rec_t       nxt  [NI];

    logic [7:0]  ldata [64];
    bit          rec_on;
    logic [23:0] rec_q [$];
    logic [23:0] qa    [$];
    int          n_ov;
    int          n_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit vs, input bit hr, input bit ce, input logic [7:0] px);
        for (int i = 0; i < NI; i++) begin
            int t;
            int maxc;
            int c;
            int eff;
            bit o;
            logic [7:0] val;
            bit kn;
            t    = tp_of(i);
            maxc = (1 << aw_of(i)) - 1;
            nxt[i].v   = 1'b0;
            nxt[i].cur = '0;
            nxt[i].t   = '0;
            nxt[i].kn  = '0;
            if (ce && hr) begin
                o   = (nline[i] > maxc);
                c   = o ? maxc : nline[i];
                eff = o ? 0 : mlc[i];
                nxt[i].v   = 1'b1;
                nxt[i].cur = px;
                for (int k = 0; k < t; k++) begin
                    if (k < eff) begin
                        val = hist[i][k][c];
                        kn  = hkn[i][k][c];
                    end else if (bm_of(i) == 0) begin
                        val = 8'd0;
                        kn  = 1'b1;
                    end else if (eff == 0) begin
                        val = px;
                        kn  = 1'b1;
                    end else begin
                        val = hist[i][eff-1][c];
                        kn  = hkn[i][eff-1][c];
                    end
                    nxt[i].t[k*8 +: 8] = val;
                    nxt[i].kn[k]       = kn;
                end
                if (o) begin
                    movf[i] = 1'b1;
                end else begin
                    for (int k = t - 1; k >= 1; k--) begin
                        hist[i][k][c] = hist[i][k-1][c];
                        hkn[i][k][c]  = hkn[i][k-1][c];
                    end
                    hist[i][0][c] = px;
                    hkn[i][0][c]  = 1'b1;
                end
                nline[i]++;
                had[i] = 1'b1;
            end
            if (!hr) nline[i] = 0;
            if (hr_prev && !hr) begin
                if (had[i] && mlc[i] < t) mlc[i]++;
                had[i] = 1'b0;
            end
            if (vs && !vs_prev) begin
                mlc[i]  = 0;
                movf[i] = 1'b0;
            end
        end
        hr_prev = hr;
        vs_prev = vs;
    endtask

    task automatic compare_all(input bit acc);
        for (int i = 0; i < NI; i++) begin
            logic [31:0] tv;
            tv = taps_of(i);
            check_eq($sformatf("d%0d out_valid", i), 32'(ov[i]), 32'(last[i].v));
            if (last[i].v) begin
                check_eq($sformatf("d%0d cur_pix", i), 32'(cp[i]), 32'(last[i].cur));
                for (int k = 0; k < tp_of(i); k++) begin
                    if (last[i].kn[k]) begin
                        check_eq($sformatf("d%0d tap%0d", i, k), 32'(tv[k*8 +: 8]),
                                 32'(last[i].t[k*8 +: 8]));
                    end
                end
            end
            check_eq($sformatf("d%0d line_cnt", i), 32'(lc[i]), 32'(mlc[i]));
            check_eq($sformatf("d%0d lines_ready", i), 32'(lr[i]), 32'(mlc[i] == tp_of(i)));
            check_eq($sformatf("d%0d overflow", i), 32'(of[i]), 32'(movf[i]));
        end
        if (rec_on) begin
            if (ov[0]) rec_q.push_back({cp[0], tp0});
            n_ov  += int'(ov[0]);
            n_acc += int'(acc);
        end
    endtask

    // One clock: drive, predict, then check just after the rising edge.
    task automatic cycle(input bit vs, input bit hr, input bit ce, input logic [7:0] px);
        vsync   = vs;
        href    = hr;
        clken   = ce;
        shiftin = px;
        model_step(vs, hr, ce, px);
        @(posedge clock);
        #1;
        compare_all(ce && hr);
        for (int i = 0; i < NI; i++) last[i] = nxt[i];
    endtask

    task automatic new_frame();
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Send len pixels from ldata with a given clken gap percentage, then end the line.
    task automatic send_line(input int len, input int gap_pct, input int idle);
        int sent;
        bit ce;
        sent = 0;
        while (sent < len) begin
            ce = ($urandom_range(99) >= 32'(gap_pct));
            cycle(1'b0, 1'b1, ce, ce ? ldata[sent] : 8'($urandom));
            if (ce) sent++;
        end
        for (int j = 0; j < idle; j++) cycle(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s d%0d out_valid", tag, i), 32'(ov[i]), 32'd0);
            check_eq($sformatf("%s d%0d cur_pix", tag, i), 32'(cp[i]), 32'd0);
            check_eq($sformatf("%s d%0d taps", tag, i), taps_of(i), 32'd0);
            check_eq($sformatf("%s d%0d line_cnt", tag, i), 32'(lc[i]), 32'd0);
            check_eq($sformatf("%s d%0d lines_ready", tag, i), 32'(lr[i]), 32'd0);
            check_eq($sformatf("%s d%0d overflow", tag, i), 32'(of[i]), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mlc[i]     = 0;
            movf[i]    = 1'b0;
            nline[i]   = 0;
            had[i]     = 1'b0;
            last[i].v  = 1'b0;
        end
        hr_prev = 1'b0;
        vs_prev = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        clken   = 1'b0;
        shiftin = 8'd0;
        rec_on  = 1'b0;
        n_ov    = 0;
        n_acc   = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'd0);

        // Three 16-pixel lines, pixel = line*16 + col.
        new_frame();
        for (int ln = 0; ln < 3; ln++) begin
            for (int c = 0; c < 16; c++) begin
                cycle(1'b0, 1'b1, 1'b1, 8'(ln * 16 + c));
                if (ln == 0 && c == 0) check_eq("latency one clk", 32'(ov[0]), 32'd0);
                if (ln == 0 && c == 1) check_eq("latency two clk", 32'(ov[0]), 32'd1);
                if (ln == 0 && c == 4) begin
                    check_eq("border0 cur", 32'(cp[0]), 32'd3);
                    check_eq("border0 taps", 32'(tp0), 32'd0);
                    check_eq("border0 line_cnt", 32'(lc[0]), 32'd0);
                    check_eq("border1 taps", 32'(tp1), 32'h0303);
                end
                if (ln == 2 && c == 6) begin
                    check_eq("line2 col5 cur", 32'(cp[0]), 32'd37);
                    check_eq("line2 col5 taps", 32'(tp0), 32'h0515);
                end
            end
            cycle(1'b0, 1'b0, 1'b0, 8'd0);
            cycle(1'b0, 1'b0, 1'b0, 8'd0);
        end
        check_eq("three lines saturate", 32'(lc[0]), 32'd2);

        // Same four lines gap-free and with 50% clken gaps give the same stream.
        for (int pass = 0; pass < 2; pass++) begin
            new_frame();
            rec_q.delete();
            rec_on = 1'b1;
            n_ov   = 0;
            n_acc  = 0;
            for (int ln = 0; ln < 4; ln++) begin
                for (int c = 0; c < 16; c++) ldata[c] = 8'((ln * 37 + c * 11) ^ 8'h5a);
                send_line(16, pass == 0 ? 0 : 50, 2);
            end
            rec_on = 1'b0;
            if (pass == 0) qa = rec_q;
        end
        check_eq("gap out_valid count", 32'(n_ov), 32'(n_acc));
        check_eq("gap accept count", 32'(n_acc), 32'd64);
        check_eq("gap stream length", 32'(rec_q.size()), 32'(qa.size()));
        for (int j = 0; j < qa.size() && j < rec_q.size(); j++) begin
            check_eq($sformatf("gap stream %0d", j), 32'(rec_q[j]), 32'(qa[j]));
        end

        // Overflow on a 20-pixel line with a 16-entry column space.
        new_frame();
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(200 + c));
            if (c == 15) check_eq("ovf before 17th", 32'(of[0]), 32'd0);
            if (c == 16) check_eq("ovf at 17th", 32'(of[0]), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 16; c++) ldata[c] = 8'(c * 3);
        send_line(16, 0, 2);
        check_eq("ovf sticky", 32'(of[0]), 32'd1);
        new_frame();
        check_eq("ovf cleared by vsync", 32'(of[0]), 32'd0);
        check_eq("line_cnt cleared by vsync", 32'(lc[0]), 32'd0);

        // vsync rise coinciding with href fall, then an empty href pulse.
        for (int c = 0; c < 4; c++) ldata[c] = 8'(c + 1);
        send_line(4, 0, 2);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b1, 8'(c + 9));
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        check_eq("vsync wins line_cnt", 32'(lc[0]), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        send_line(4, 0, 2);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("empty href no count", 32'(lc[0]), 32'd1);

        // Reset asserted in the middle of the second line.
        new_frame();
        for (int c = 0; c < 16; c++) ldata[c] = 8'(c + 50);
        send_line(16, 0, 2);
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, 1'b1, 8'(c + 80));
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        new_frame();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(100 + c));
            if (c == 4) begin
                check_eq("post reset taps d0", 32'(tp0), 32'd0);
                check_eq("post reset taps d1", 32'(tp1), 32'h6767);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);

        // Random frames: variable line lengths, clken gaps and blanking.
        for (int f = 0; f < 6; f++) begin
            int nl;
            new_frame();
            nl = int'($urandom_range(6, 3));
            for (int ln = 0; ln < nl; ln++) begin
                int len;
                len = int'($urandom_range(20, 1));
                for (int c = 0; c < len; c++) ldata[c] = 8'($urandom);
                send_line(len, 30, int'($urandom_range(3, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
